// File: rtl/fetch_buffer.sv
// Instruction prefetch queue between fetch and decode: circular buffer of {instruction, PCPlus4}
// pairs with branch flush and a stop-on-halt-word fetch block.
module fetch_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instruction,
  input  logic [31:0]              in_PCPlus4,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instruction,
  output logic [31:0]              out_PCPlus4,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [63:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          halted_q;
  logic          full, empty, push, pop;
  logic [AW-1:0] wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign full  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  always_comb begin
    in_ready        = !full && !halted_q && !flush;
    out_valid       = !empty;
    push            = in_valid && in_ready;
    pop             = out_valid && out_ready;
    out_instruction = NOP_WORD;
    out_PCPlus4     = 32'h0;
    if (!empty) begin
      out_instruction = mem_q[rd_idx][63:32];
      out_PCPlus4     = mem_q[rd_idx][31:0];
    end
    count  = wr_ptr_q - rd_ptr_q;
    halted = halted_q;
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      halted_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (in_instruction == HALT_WORD) halted_q <= 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; push is already blocked during flush.
  always_ff @(posedge CLK) begin
    if (push && !RST) mem_q[wr_idx] <= {in_instruction, in_PCPlus4};
  end

endmodule
